// File: rtl/gb_arbiter.sv
// Global buffer arbiter: grants one requester per cycle (round-robin or fixed priority),
// registers the access toward the buffer and steers read returns back via an in-order tag FIFO.
module gb_arbiter #(
  parameter int numRequesters  = 4,
  parameter int addrWidth      = 10,
  parameter int dataSize       = 8,
  parameter int interfaceDepth = 16,
  parameter int maxOutstanding = 4
) (
  input  logic                                       clk,
  input  logic                                       nrst,
  input  logic                                       arb_mode_i,
  input  logic [numRequesters-1:0]                   req_valid_i,
  output logic [numRequesters-1:0]                   req_ready_o,
  input  logic [numRequesters-1:0]                   req_wr_en_i,
  input  logic [numRequesters*addrWidth-1:0]         req_addr_i,
  input  logic [numRequesters*dataSize*interfaceDepth-1:0] req_wr_data_i,
  output logic [numRequesters-1:0]                   rsp_valid_o,
  output logic [dataSize*interfaceDepth-1:0]         rsp_data_o,
  output logic [addrWidth-1:0]                       gb_addr_o,
  output logic [dataSize*interfaceDepth-1:0]         gb_wr_data_o,
  output logic                                       gb_wr_en_o,
  output logic                                       gb_rd_en_o,
  input  logic [dataSize*interfaceDepth-1:0]         gb_rd_data_i,
  input  logic                                       gb_valid_i,
  output logic                                       err_o
);

  localparam int BUS_W = dataSize * interfaceDepth;
  localparam int IDX_W = (numRequesters > 1) ? $clog2(numRequesters) : 1;
  localparam int PTR_W = (maxOutstanding > 1) ? $clog2(maxOutstanding) : 1;
  localparam int CNT_W = $clog2(maxOutstanding + 1);

  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         tag_mem [maxOutstanding];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         tag_cnt;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;
  logic                     push;
  logic                     read_ok;
  logic [numRequesters-1:0] elig_p0;
  logic                     gnt_vld_p0;
  logic [IDX_W-1:0]         gnt_idx_p0;
  logic [IDX_W-1:0]         cand;
  logic                     gnt_wr_p0;

  assign fifo_full  = (tag_cnt == CNT_W'(maxOutstanding));
  assign fifo_empty = (tag_cnt == '0);
  assign pop        = gb_valid_i & ~fifo_empty;
  // A same-cycle pop frees a slot, so a read may be granted into a full FIFO.
  assign read_ok    = ~fifo_full | pop;
  assign elig_p0    = req_valid_i & (req_wr_en_i | {numRequesters{read_ok}});

  // Stage p0: combinational grant selection
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    cand       = '0;
    for (int i = 0; i < numRequesters; i++) begin
      cand = arb_mode_i ? IDX_W'(i) : IDX_W'((int'(rr_ptr) + i) % numRequesters);
      if (!gnt_vld_p0 && elig_p0[cand]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = cand;
      end
    end
  end

  assign req_ready_o = gnt_vld_p0 ? (numRequesters'(1) << gnt_idx_p0) : '0;
  assign gnt_wr_p0   = req_wr_en_i[gnt_idx_p0];
  assign push        = gnt_vld_p0 & ~gnt_wr_p0;

  // Stage p1: registered buffer access, tag bookkeeping and read return
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tag_cnt      <= '0;
      gb_addr_o    <= '0;
      gb_wr_data_o <= '0;
      gb_wr_en_o   <= 1'b0;
      gb_rd_en_o   <= 1'b0;
      rsp_valid_o  <= '0;
      rsp_data_o   <= '0;
      err_o        <= 1'b0;
    end else begin
      gb_wr_en_o <= 1'b0;
      gb_rd_en_o <= 1'b0;
      if (gnt_vld_p0) begin
        gb_addr_o  <= req_addr_i[gnt_idx_p0*addrWidth +: addrWidth];
        gb_wr_en_o <= gnt_wr_p0;
        gb_rd_en_o <= ~gnt_wr_p0;
        if (gnt_wr_p0)
          gb_wr_data_o <= req_wr_data_i[gnt_idx_p0*BUS_W +: BUS_W];
        if (!arb_mode_i)
          rr_ptr <= (gnt_idx_p0 == IDX_W'(numRequesters - 1)) ? '0 : gnt_idx_p0 + 1'b1;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      rsp_valid_o <= '0;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        rsp_valid_o <= numRequesters'(1) << tag_mem[rd_ptr];
        rsp_data_o  <= gb_rd_data_i;
      end
      tag_cnt <= tag_cnt + CNT_W'(push) - CNT_W'(pop);
      if (gb_valid_i && fifo_empty)
        err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= gnt_idx_p0;
  end

endmodule

// File: tb/tb_gb_arbiter.sv
// Scoreboard bench for gb_arbiter: expected buffer accesses and read returns are queued at
// stimulus time and compared by negedge monitors as the design produces them.
module tb_gb_arbiter;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int BW = 128;

  logic              clk = 1'b0;
  logic              nrst;
  logic              arb_mode;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_wr_en;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*BW-1:0]  req_wr_data;
  logic [NR-1:0]     rsp_valid;
  logic [BW-1:0]     rsp_data;
  logic [AW-1:0]     gb_addr;
  logic [BW-1:0]     gb_wr_data;
  logic              gb_wr_en;
  logic              gb_rd_en;
  logic [BW-1:0]     gb_rd_data;
  logic              gb_valid;
  logic              err;

  int checks   = 0;
  int failures = 0;

  logic [AW+BW+1:0] gbq [$];
  logic [NR+BW-1:0] rspq [$];

  gb_arbiter dut (
    .clk           (clk),
    .nrst          (nrst),
    .arb_mode_i    (arb_mode),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_wr_en_i   (req_wr_en),
    .req_addr_i    (req_addr),
    .req_wr_data_i (req_wr_data),
    .rsp_valid_o   (rsp_valid),
    .rsp_data_o    (rsp_data),
    .gb_addr_o     (gb_addr),
    .gb_wr_data_o  (gb_wr_data),
    .gb_wr_en_o    (gb_wr_en),
    .gb_rd_en_o    (gb_rd_en),
    .gb_rd_data_i  (gb_rd_data),
    .gb_valid_i    (gb_valid),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [BW-1:0] wd(input int k);
    logic [7:0] b;
    b = 8'h30 + k[7:0];
    return rep(b);
  endfunction

  function automatic logic [AW+BW+1:0] gbe(input logic wr, input logic [AW-1:0] a,
                                           input logic [BW-1:0] d);
    return {wr, ~wr, a, d};
  endfunction

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] d);
    req_wr_en[k]          = wr;
    req_addr[k*AW +: AW]  = a;
    req_wr_data[k*BW +: BW] = d;
  endtask

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  // Buffer access monitor; read accesses compare strobes and address only.
  always @(negedge clk) begin
    if (gb_wr_en === 1'b1 || gb_rd_en === 1'b1) begin
      chk("gb_pending", 256'(gbq.size() != 0), 256'(1));
      if (gbq.size() != 0) begin
        logic [AW+BW+1:0] e;
        e = gbq.pop_front();
        if (e[AW+BW])
          chk("gb_rd_access", 256'({gb_wr_en, gb_rd_en, gb_addr}), 256'(e[AW+BW+1:BW]));
        else
          chk("gb_wr_access", 256'({gb_wr_en, gb_rd_en, gb_addr, gb_wr_data}), 256'(e));
      end
    end
    if (rsp_valid !== '0) begin
      chk("rsp_pending", 256'(rspq.size() != 0), 256'(1));
      if (rspq.size() != 0)
        chk("rsp", 256'({rsp_valid, rsp_data}), 256'(rspq.pop_front()));
    end
  end

  initial begin
    nrst = 1'b0; arb_mode = 1'b0; req_valid = '0; req_wr_en = '0; req_addr = '0;
    req_wr_data = '0; gb_rd_data = '0; gb_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", 256'(req_ready), 256'(0));
    chk("rst_strobes", 256'({gb_wr_en, gb_rd_en}), 256'(0));
    chk("rst_addr", 256'(gb_addr), 256'(0));
    chk("rst_rsp", 256'(rsp_valid), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    drive_pt();
    nrst = 1'b1;

    // Round-robin, all four writing continuously
    arb_mode = 1'b0;
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, AW'(16 + k), wd(k));
    req_valid = 4'hF;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("rr_ready", 256'(req_ready), 256'(4'b0001 << (n % 4)));
      gbq.push_back(gbe(1'b1, AW'(16 + n % 4), wd(n % 4)));
      drive_pt();
    end
    req_valid = '0;

    // Single read from requester 2
    set_req(2, 1'b0, 10'h005, '0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("s1_ready", 256'(req_ready), 256'(4'b0100));
    gbq.push_back(gbe(1'b0, 10'h005, '0));
    drive_pt();
    req_valid = '0;
    @(negedge clk);
    chk("s1_rd_en", 256'({gb_wr_en, gb_rd_en}), 256'(2'b01));
    chk("s1_addr", 256'(gb_addr), 256'(10'h005));
    drive_pt();
    gb_valid = 1'b1; gb_rd_data = rep(8'hAB);
    rspq.push_back({4'b0100, rep(8'hAB)});
    drive_pt();
    gb_valid = 1'b0;
    @(negedge clk);
    chk("s1_rsp_valid", 256'(rsp_valid), 256'(4'b0100));
    chk("s1_rsp_data", 256'(rsp_data), 256'(rep(8'hAB)));

    // Fixed priority: requester 1 starves requester 3
    drive_pt();
    arb_mode = 1'b1;
    set_req(1, 1'b1, 10'h021, wd(1));
    set_req(3, 1'b1, 10'h023, wd(3));
    req_valid = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("fp_ready", 256'(req_ready), 256'(4'b0010));
      gbq.push_back(gbe(1'b1, 10'h021, wd(1)));
      drive_pt();
    end
    req_valid = 4'b1000;
    @(negedge clk);
    chk("fp_ready3", 256'(req_ready), 256'(4'b1000));
    gbq.push_back(gbe(1'b1, 10'h023, wd(3)));
    drive_pt();
    req_valid = '0;

    // Fill the tag FIFO with four reads, one per requester
    for (int i = 0; i < NR; i++) begin
      set_req(i, 1'b0, AW'(64 + i), '0);
      req_valid = NR'(1) << i;
      @(negedge clk);
      chk("ff_fill", 256'(req_ready), 256'(4'b0001 << i));
      gbq.push_back(gbe(1'b0, AW'(64 + i), '0));
      drive_pt();
    end
    set_req(0, 1'b0, 10'h044, '0);
    set_req(1, 1'b1, 10'h050, wd(5));
    req_valid = 4'b0011;
    @(negedge clk);
    chk("ff_block", 256'(req_ready), 256'(4'b0010));
    gbq.push_back(gbe(1'b1, 10'h050, wd(5)));
    drive_pt();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("ff_full", 256'(req_ready), 256'(0));
    drive_pt();
    gb_valid = 1'b1; gb_rd_data = rep(8'hC0);
    @(negedge clk);
    chk("ff_pop_grant", 256'(req_ready), 256'(4'b0001));
    gbq.push_back(gbe(1'b0, 10'h044, '0));
    rspq.push_back({4'b0001, rep(8'hC0)});
    drive_pt();
    req_valid = '0;
    for (int i = 1; i < 5; i++) begin
      logic [7:0] b;
      b = 8'hC0 + 8'(i);
      gb_rd_data = rep(b);
      rspq.push_back({4'b0001 << (i % 4), rep(b)});
      drive_pt();
    end
    gb_valid = 1'b0;
    @(negedge clk);
    chk("ff_no_err", 256'(err), 256'(0));
    drive_pt();

    // Read data with nothing outstanding
    gb_valid = 1'b1; gb_rd_data = rep(8'hEE);
    drive_pt();
    gb_valid = 1'b0;
    @(negedge clk);
    chk("err_set", 256'(err), 256'(1));
    chk("err_no_rsp", 256'(rsp_valid), 256'(0));
    repeat (3) drive_pt();
    @(negedge clk);
    chk("err_sticky", 256'(err), 256'(1));

    // Reset with two reads outstanding
    drive_pt();
    arb_mode = 1'b1;
    set_req(2, 1'b0, 10'h062, '0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("rs_ready2", 256'(req_ready), 256'(4'b0100));
    gbq.push_back(gbe(1'b0, 10'h062, '0));
    drive_pt();
    set_req(3, 1'b0, 10'h063, '0);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("rs_ready3", 256'(req_ready), 256'(4'b1000));
    gbq.push_back(gbe(1'b0, 10'h063, '0));
    drive_pt();
    req_valid = '0;
    drive_pt();
    drive_pt();
    #2;
    nrst = 1'b0;
    #1;
    chk("rs_ready", 256'(req_ready), 256'(0));
    chk("rs_strobes", 256'({gb_wr_en, gb_rd_en}), 256'(0));
    chk("rs_addr", 256'(gb_addr), 256'(0));
    chk("rs_wr_data", 256'(gb_wr_data), 256'(0));
    chk("rs_rsp", 256'({rsp_valid, rsp_data}), 256'(0));
    chk("rs_err", 256'(err), 256'(0));
    drive_pt();
    drive_pt();
    nrst = 1'b1;
    arb_mode = 1'b0;
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, AW'(112 + k), wd(k));
    req_valid = 4'hF;
    @(negedge clk);
    chk("rs_first_grant", 256'(req_ready), 256'(4'b0001));
    gbq.push_back(gbe(1'b1, 10'h070, wd(0)));
    drive_pt();
    req_valid = '0;
    gb_valid = 1'b1; gb_rd_data = rep(8'h5A);
    drive_pt();
    gb_valid = 1'b0;
    @(negedge clk);
    chk("rs_fifo_empty_err", 256'(err), 256'(1));
    chk("rs_no_rsp", 256'(rsp_valid), 256'(0));

    repeat (3) drive_pt();
    chk("gbq_drained", 256'(gbq.size()), 256'(0));
    chk("rspq_drained", 256'(rspq.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_arbiter.md
Name: gb_arbiter

Overview:
- Shares the single-port global buffer between several requesters: ifmap/filter/psum readers and the DMA writer.
- Per-requester valid/ready handshake; round-robin or fixed-priority grant; one registered access per cycle to the global buffer.
- Tracks outstanding reads in a tag FIFO and routes returned read data back to the requester that issued it.
- Sits between the PE-array feeders/DMA and global_buffer inside the accelerator top.

Parameters:
- numRequesters, 4, number of requester ports.
- addrWidth, 10, global buffer address width (log2 of 1024-entry depth).
- dataSize, 8, bits per word.
- interfaceDepth, 16, words per global buffer access; bus width is dataSize*interfaceDepth.
- maxOutstanding, 4, depth of the read tag FIFO (power of 2).

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- arb_mode_i  in  1  0 = round-robin, 1 = fixed priority (index 0 highest).
- req_valid_i  in  numRequesters  request valid, one bit per requester.
- req_ready_o  out  numRequesters  request accepted this cycle (one-hot or zero).
- req_wr_en_i  in  numRequesters  1 = write, 0 = read.
- req_addr_i  in  numRequesters*addrWidth  packed addresses, requester k at slice k.
- req_wr_data_i  in  numRequesters*dataSize*interfaceDepth  packed write data.
- rsp_valid_o  out  numRequesters  one-hot read-data return.
- rsp_data_o  out  dataSize*interfaceDepth  read data, qualified by rsp_valid_o.
- gb_addr_o  out  addrWidth  global buffer address.
- gb_wr_data_o  out  dataSize*interfaceDepth  global buffer write data.
- gb_wr_en_o  out  1  global buffer write strobe.
- gb_rd_en_o  out  1  global buffer read strobe.
- gb_rd_data_i  in  dataSize*interfaceDepth  global buffer read data.
- gb_valid_i  in  1  global buffer read data valid.
- err_o  out  1  sticky: read data returned with no read outstanding.

Behaviour:
- Reset (async, nrst low): all outputs 0; rr pointer = 0; tag FIFO empty; err_o = 0.
- Handshake:
  - A requester holds valid, wr_en, addr and data stable until it sees ready.
  - Transfer occurs when req_valid_i[k] & req_ready_o[k] at a rising edge.
  - req_ready_o is combinational and at most one bit is set.
- Eligibility:
  - Requester k is eligible if req_valid_i[k] is set, and either it is a write, or it is a read and the tag FIFO is not full.
  - Reads are blocked when the FIFO is full and no pop is happening that cycle.
  - A simultaneous pop (gb_valid_i=1) frees a slot in the same cycle, so a read may be granted.
- Grant:
  - Round-robin: first eligible requester starting at the rr pointer, wrapping modulo numRequesters. After a transfer from k, pointer = (k+1) mod numRequesters.
  - Fixed priority: lowest eligible index; pointer unchanged.
  - No eligible requester: no grant, pointer holds.
- Issue:
  - Transfer in cycle N → gb_addr_o/gb_wr_data_o and exactly one of gb_wr_en_o/gb_rd_en_o driven in cycle N+1 for one cycle.
  - Strobes are 0 in idle cycles; gb_addr_o/gb_wr_data_o hold their last value.
- Read tag:
  - On a read transfer, push the requester index into the tag FIFO.
  - On gb_valid_i, pop the head. Cycle after the pop: rsp_valid_o[head] = 1 and rsp_data_o = the gb_rd_data_i captured at the pop.
  - Returns are in order. Push and pop may occur in the same cycle, including when the FIFO is full or empty-with-push.
- Error: gb_valid_i while the FIFO is empty → err_o set and held until reset; no rsp_valid_o; FIFO unchanged.
- Writes produce no response.
- Reset mid-operation clears outstanding tags; later gb_valid_i returns flag err_o.

Test Plan:
- Single read, requester 2, addr 0x05 → gb_rd_en_o=1 with gb_addr_o=0x05 one cycle after handshake; buffer returns 0xAB.. → rsp_valid_o=4'b0100 with that data one cycle after gb_valid_i.
- All 4 requesters continuously valid, round-robin → grant order 0,1,2,3,0,1 over 6 cycles; each req_ready_o pulses once per 4 cycles.
- Fixed priority with req_valid_i=4'b1010 → requester 1 granted every cycle; requester 3 starved until requester 1 deasserts.
- 4 reads with gb_valid_i held 0 → FIFO full, 5th read not granted while a write from another requester is granted; then one gb_valid_i → 5th read granted in that same cycle.
- gb_valid_i pulse with no read outstanding → err_o=1 and sticky; no rsp_valid_o.
- nrst asserted with 2 reads outstanding → all outputs 0 immediately; after release, first grant goes to requester 0 and the FIFO is empty.
